// File: rtl/shift_align_pipe.sv
// Pipelined multi-mode barrel shifter (logical/arith right, left, rotate) with sticky; SHIFT_ALIGN_STICKY_EN builds sticky logic.
// Latency: ceil(SHIFT_W/LEVELS_PER_STAGE) cycles, one beat per cycle.
// Backpressure: valid/ready per stage, bubbles collapse, in_ready follows out_ready combinationally.
module shift_align_pipe #(
  parameter int WIDTH            = 24,
  parameter int SHIFT_W          = 5,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_W            = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sticky,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int N = (SHIFT_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic [SHIFT_W-1:0] shift;
    logic [1:0]         op;
`ifdef SHIFT_ALIGN_STICKY_EN
    logic               sticky;
`endif
    logic [TAG_W-1:0]   tag;
  } beat_t;

  // One mux level: shift by 2^k when shift bit k is set; rotate wraps modulo WIDTH.
  function automatic beat_t apply_level(input beat_t b, input int k);
    beat_t r;
    int    amt;
    int    rot;
`ifdef SHIFT_ALIGN_STICKY_EN
    logic  drop;
`endif
    r   = b;
    amt = 1 << k;
    rot = amt % WIDTH;
`ifdef SHIFT_ALIGN_STICKY_EN
    drop = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < amt) drop = drop | b.data[i];
    end
`endif
    if (b.shift[k]) begin
      case (b.op)
        OP_SRL:  r.data = b.data >> amt;
        OP_SRA:  r.data = $signed(b.data) >>> amt;
        OP_SLL:  r.data = b.data << amt;
        default: begin
          if (rot != 0) r.data = (b.data >> rot) | (b.data << (WIDTH - rot));
        end
      endcase
`ifdef SHIFT_ALIGN_STICKY_EN
      if (!b.op[1]) r.sticky = b.sticky | drop;
`endif
    end
    return r;
  endfunction

  beat_t        head;
  beat_t        st [N];
  logic [N-1:0] vld;
  logic [N-1:0] load;

  always_comb begin
    head       = '0;
    head.data  = in_data;
    head.shift = in_shift;
    head.op    = in_op;
    head.tag   = in_tag;
  end

  for (genvar s = 0; s < N; s++) begin : g_stage
    localparam int LO = s * LEVELS_PER_STAGE;
    localparam int HI = (LO + LEVELS_PER_STAGE > SHIFT_W) ? SHIFT_W : LO + LEVELS_PER_STAGE;

    beat_t src;
    logic  src_vld;
    beat_t lvl;

    if (s == 0) begin : g_src
      assign src     = head;
      assign src_vld = in_valid;
    end else begin : g_src
      assign src     = st[s-1];
      assign src_vld = vld[s-1];
    end

    if (s == N - 1) begin : g_load
      assign load[s] = !vld[s] || out_ready;
    end else begin : g_load
      assign load[s] = !vld[s] || load[s+1];
    end

    always_comb begin
      lvl = src;
      for (int k = LO; k < HI; k++) lvl = apply_level(lvl, k);
    end

    // Payload only moves with a real beat so a stalled output stays put.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld[s] <= 1'b0;
        st[s]  <= '0;
      end else if (load[s]) begin
        vld[s] <= src_vld;
        if (src_vld) st[s] <= lvl;
      end
    end
  end

  assign in_ready  = load[0] && !reset;
  assign out_valid = vld[N-1];
  assign out_data  = st[N-1].data;
  assign out_tag   = st[N-1].tag;
`ifdef SHIFT_ALIGN_STICKY_EN
  assign out_sticky = st[N-1].sticky;
`else
  assign out_sticky = 1'b0;
`endif

  // Consumed shift bits and the final op copy are carried but never read again.
  logic unused_bits;
  always_comb begin
    unused_bits = 1'b0;
    for (int i = 0; i < N; i++) unused_bits = unused_bits ^ (^st[i]);
  end

endmodule

// File: tb/tb_shift_align_pipe.sv
// Scoreboard bench for shift_align_pipe: directed alignment cases, backpressure, reset flush, random traffic.
module tb_shift_align_pipe;
  localparam int W  = 24;
  localparam int SW = 5;
  localparam int TW = 4;
`ifdef SHIFT_ALIGN_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_shift = '0;
  logic [1:0]    in_op = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_sticky;
  logic [TW-1:0] out_tag;

  shift_align_pipe #(.WIDTH(W), .SHIFT_W(SW), .LEVELS_PER_STAGE(2), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shift(in_shift),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sticky(out_sticky), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  data;
    logic          sticky;
    logic [TW-1:0] tag;
    bit            lat;
    int            cyc;
  } exp_t;
  exp_t q[$];

  logic [W-1:0] cur_exp_d = '0;
  logic         cur_exp_st = 1'b0;
  bit           cur_lat = 1'b0;
  bit           done = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Bit-level reference: output bit i picks its source bit directly.
  task automatic model(input logic [W-1:0] d, input int s, input logic [1:0] op,
                       output logic [W-1:0] r, output logic st);
    r  = '0;
    st = 1'b0;
    for (int i = 0; i < W; i++) begin
      case (op)
        2'b00:   r[i] = (i + s < W) ? d[(i + s) % W] : 1'b0;
        2'b01:   r[i] = (i + s < W) ? d[(i + s) % W] : d[W-1];
        2'b10:   r[i] = (i >= s) ? d[(i - s + W) % W] : 1'b0;
        default: r[i] = d[(i + s) % W];
      endcase
      if (!op[1] && i < s) st = st | d[i];
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic [SW-1:0] s, input logic [1:0] op,
                      input logic [TW-1:0] t, input logic [W-1:0] ed, input logic es, input bit lat);
    int n = 0;
    in_valid   = 1'b1;
    in_data    = d;
    in_shift   = s;
    in_op      = op;
    in_tag     = t;
    cur_exp_d  = ed;
    cur_exp_st = es & STICKY;
    cur_lat    = lat;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [W-1:0] d, input logic [SW-1:0] s, input logic [1:0] op,
                            input logic [TW-1:0] t, input bit lat);
    logic [W-1:0] ed;
    logic         es;
    model(d, int'(s), op, ed, es);
    send(d, s, op, t, ed, es, lat);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop/compare on output transfer, push on input transfer, watch stall stability.
  initial begin
    exp_t          e;
    logic          stall_q = 1'b0;
    logic [W-1:0]  hd = '0;
    logic          hs = 1'b0;
    logic [TW-1:0] ht = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          check("hold_valid", out_valid, 32'd1);
          check("hold_data", out_data, hd);
          check("hold_sticky", out_sticky, hs);
          check("hold_tag", out_tag, ht);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check("spurious_out", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check("out_data", out_data, e.data);
            check("out_sticky", out_sticky, e.sticky);
            check("out_tag", out_tag, e.tag);
            if (e.lat) check("latency", cyc - e.cyc, 32'd3);
          end
        end
        if (in_valid && in_ready) begin
          e.data   = cur_exp_d;
          e.sticky = cur_exp_st;
          e.tag    = in_tag;
          e.lat    = cur_lat;
          e.cyc    = cyc;
          q.push_back(e);
        end
        stall_q = out_valid && !out_ready;
        hd = out_data;
        hs = out_sticky;
        ht = out_tag;
      end
    end
  end

  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
    logic [1:0]    op;
    logic [W-1:0]  ed;
    logic          es;
  } vec_t;

  vec_t vecs [9] = '{
    '{24'h800001, 5'd1,  2'b00, 24'h400000, 1'b1},
    '{24'h800001, 5'd31, 2'b00, 24'h000000, 1'b1},
    '{24'h800000, 5'd4,  2'b01, 24'hF80000, 1'b0},
    '{24'h80000F, 5'd4,  2'b01, 24'hF80000, 1'b1},
    '{24'h000001, 5'd23, 2'b10, 24'h800000, 1'b0},
    '{24'h000001, 5'd24, 2'b10, 24'h000000, 1'b0},
    '{24'h000001, 5'd1,  2'b11, 24'h800000, 1'b0},
    '{24'h000001, 5'd25, 2'b11, 24'h800000, 1'b0},
    '{24'h000001, 5'd31, 2'b11, 24'h020000, 1'b0}
  };

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_in_ready", in_ready, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_sticky", out_sticky, 32'd0);
    check("rst_out_tag", out_tag, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", in_ready, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Directed alignment cases, back-to-back, latency checked on each.
    for (int i = 0; i < 9; i++)
      send(vecs[i].d, vecs[i].s, vecs[i].op, TW'(i), vecs[i].ed, vecs[i].es, 1'b1);
    wait_drain();

    // Backpressure: capacity of three, then release with simultaneous accept/emit.
    out_ready = 1'b0;
    fork
      begin
        for (int t = 1; t <= 5; t++)
          send_model(24'h111111 * t, SW'(t), 2'b00, TW'(t), 1'b0);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, (i < 3) ? 32'd1 : 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("bp_stream_valid", out_valid, 32'd1);
        end
      end
    join
    wait_drain();

    // Reset with two beats in flight: they must vanish.
    send_model(24'h00ABCD, 5'd3, 2'b00, 4'd6, 1'b0);
    send_model(24'h00F0F0, 5'd2, 2'b10, 4'd7, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mid_rst_out_valid", out_valid, 32'd0);
      check("mid_rst_in_ready", in_ready, 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 32'd1);
    check("post_rst_out_valid", out_valid, 32'd0);
    @(posedge clk);
    #1;
    send_model(24'h123456, 5'd5, 2'b01, 4'd8, 1'b1);
    wait_drain();

    // Random traffic with random bubbles and consumer stalls.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send_model(W'($urandom), SW'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                     TW'($urandom_range(0, 15)), 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
